// File: rtl/result_output_pkg.sv
// Shared constants, Booth digit encoding and tree-sizing helpers for the
// radix-8 Booth / Wallace-tree 32x32 unsigned multiplier.
package result_output_pkg;

  localparam int OP_W             = 32;
  localparam int PROD_W           = 64;
  localparam int NUM_PP           = 11;
  localparam int BOOTH_RADIX_BITS = 3;

  // Partial products plus one row carrying the +1 negation corrections
  localparam int NUM_ROWS   = NUM_PP + 1;
  localparam int NUM_LEVELS = 5;
  // Widest Booth multiple is 4a, which needs OP_W+2 bits; one spare bit
  localparam int MAG_W      = OP_W + 3;

  typedef enum logic [3:0] {
    BD_ZERO = 4'd0,
    BD_POS1 = 4'd1,
    BD_POS2 = 4'd2,
    BD_POS3 = 4'd3,
    BD_POS4 = 4'd4,
    BD_NEG1 = 4'd5,
    BD_NEG2 = 4'd6,
    BD_NEG3 = 4'd7,
    BD_NEG4 = 4'd8
  } booth_digit_e;

  // Window is {b[3i+2], b[3i+1], b[3i], b[3i-1]}; value = -4*w3 + 2*w2 + w1 + w0
  function automatic booth_digit_e booth_encode(input logic [3:0] win);
    booth_digit_e d;
    case (win)
      4'b0000: d = BD_ZERO;
      4'b0001: d = BD_POS1;
      4'b0010: d = BD_POS1;
      4'b0011: d = BD_POS2;
      4'b0100: d = BD_POS2;
      4'b0101: d = BD_POS3;
      4'b0110: d = BD_POS3;
      4'b0111: d = BD_POS4;
      4'b1000: d = BD_NEG4;
      4'b1001: d = BD_NEG3;
      4'b1010: d = BD_NEG3;
      4'b1011: d = BD_NEG2;
      4'b1100: d = BD_NEG2;
      4'b1101: d = BD_NEG1;
      4'b1110: d = BD_NEG1;
      default: d = BD_ZERO;
    endcase
    return d;
  endfunction

  function automatic logic booth_is_neg(input booth_digit_e d);
    return (d == BD_NEG1) || (d == BD_NEG2) || (d == BD_NEG3) || (d == BD_NEG4);
  endfunction

  // Rows remaining at the input of a given Wallace level (12,8,6,4,3,2)
  function automatic int rows_at(input int level);
    int n;
    n = NUM_ROWS;
    for (int l = 0; l < level; l++) begin
      n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

endpackage

// File: rtl/result_output_partial_product_generator.sv
// Radix-8 Booth recoder: produces eleven 64-bit aligned partial products
// (one's-complemented when negative) and the matching +1 correction vector.
module partial_product_generator
  import result_output_pkg::*;
(
  input  logic [OP_W-1:0]                a,
  input  logic [OP_W-1:0]                b,
  output logic [NUM_PP-1:0][PROD_W-1:0]  pp,
  output logic [NUM_PP-1:0]              neg
);

  logic [OP_W+1:0] a3;
  logic [OP_W+1:0] b_ext;

  // The only adder in the recoder: 3a = a + 2a
  assign a3    = {2'b00, a} + {1'b0, a, 1'b0};
  // Zero-extension bit on top, implicit b[-1]=0 at the bottom
  assign b_ext = {1'b0, b, 1'b0};

  always_comb begin : gen_pp
    booth_digit_e       digit;
    logic [MAG_W-1:0]   mag;
    logic [PROD_W-1:0]  row;
    logic               is_neg;
    pp  = '0;
    neg = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      digit  = booth_encode(b_ext[BOOTH_RADIX_BITS*i +: 4]);
      is_neg = booth_is_neg(digit);
      case (digit)
        BD_POS1, BD_NEG1: mag = {3'b000, a};
        BD_POS2, BD_NEG2: mag = {2'b00, a, 1'b0};
        BD_POS3, BD_NEG3: mag = {1'b0, a3};
        BD_POS4, BD_NEG4: mag = {1'b0, a, 2'b00};
        default:          mag = '0;
      endcase
      row = {{(PROD_W-MAG_W){1'b0}}, mag};
      if (is_neg) begin
        row = ~row;
      end
      // Low bits vacated by the shift are zero; the +1 lands at bit 3i
      pp[i]  = row << (BOOTH_RADIX_BITS * i);
      neg[i] = is_neg;
    end
  end

endmodule

// File: rtl/result_output.sv
// 32x32 unsigned multiplier: Booth partial products, 3:2 Wallace reduction,
// one carry-propagate adder, single output register (latency 1, throughput 1).
module result_output
  import result_output_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] out
);

  logic [NUM_PP-1:0][PROD_W-1:0] pp;
  logic [NUM_PP-1:0]             neg;
  logic [PROD_W-1:0]             corr;
  logic [PROD_W-1:0]             tree [NUM_LEVELS+1][NUM_ROWS];
  logic [PROD_W-1:0]             sum;

  partial_product_generator u_ppg (
    .a   (a),
    .b   (b),
    .pp  (pp),
    .neg (neg)
  );

  // Correction bits sit at distinct positions 3i, so they share one row
  always_comb begin
    corr = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      corr[BOOTH_RADIX_BITS*i] = neg[i];
    end
  end

  for (genvar i = 0; i < NUM_PP; i++) begin : g_load
    assign tree[0][i] = pp[i];
  end
  assign tree[0][NUM_PP] = corr;

  for (genvar l = 0; l < NUM_LEVELS; l++) begin : g_lvl
    localparam int N_IN  = rows_at(l);
    localparam int N_OUT = rows_at(l + 1);
    localparam int N_CSA = N_IN / 3;

    for (genvar j = 0; j < N_CSA; j++) begin : g_csa
      logic [PROD_W-1:0] x, y, z;
      assign x = tree[l][3*j];
      assign y = tree[l][3*j+1];
      assign z = tree[l][3*j+2];
      assign tree[l+1][2*j]   = x ^ y ^ z;
      // Carry out of bit 63 is dropped: arithmetic is mod 2^64
      assign tree[l+1][2*j+1] = ((x & y) | (x & z) | (y & z)) << 1;
    end

    for (genvar r = 0; r < N_IN % 3; r++) begin : g_pass
      assign tree[l+1][2*N_CSA+r] = tree[l][3*N_CSA+r];
    end

    for (genvar r = N_OUT; r < NUM_ROWS; r++) begin : g_idle
      assign tree[l+1][r] = '0;
    end
  end

  assign sum = tree[NUM_LEVELS][0] + tree[NUM_LEVELS][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else begin
      out <= sum;
    end
  end

endmodule

// File: tb/tb_result_output.sv
// Directed and random checks of the registered 32x32 unsigned multiplier.
module tb_result_output;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] out;

  int pass_cnt;
  int total_cnt;

  result_output dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    a = va;
    b = vb;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a = 32'd255;
    b = 32'd32;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (out !== 64'd0) $display("FAIL reset_hold out=%h exp=%h", out, 64'd0);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    total_cnt++;
    if (out !== 64'd0) $display("FAIL reset_release_pre_edge out=%h exp=%h", out, 64'd0);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (out !== 64'd8160) $display("FAIL reset_first_edge out=%h exp=%h", out, 64'd8160);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [3] = '{32'd12, 32'd12, 32'd43};
    logic [31:0] vb [3] = '{32'd74, 32'd24, 32'd7};
    logic [63:0] ve [3] = '{64'd888, 64'd288, 64'd301};
    logic [63:0] prev;
    prev = 64'd8160;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = va[i];
      b = vb[i];
      #1;
      // New operands must not reach out before the edge
      total_cnt++;
      if (out !== prev) $display("FAIL b2b_hold_%0d out=%h exp=%h", i, out, prev);
      else pass_cnt++;
      @(posedge clk);
      #1;
      total_cnt++;
      if (out !== ve[i]) $display("FAIL b2b_%0d out=%h exp=%h", i, out, ve[i]);
      else pass_cnt++;
      prev = ve[i];
    end
  endtask

  task automatic test_extremes();
    logic [31:0] va [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1234_5678};
    logic [31:0] vb [4] = '{32'hFFFF_FFFF, 32'h1, 32'h1234_5678, 32'h0};
    logic [63:0] ve [4] = '{64'hFFFF_FFFE_0000_0001, 64'h0000_0000_FFFF_FFFF,
                            64'h0, 64'h0};
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i]);
      total_cnt++;
      if (out !== ve[i]) $display("FAIL extreme_%0d out=%h exp=%h", i, out, ve[i]);
      else pass_cnt++;
    end
    drive(32'd3, 32'hFFFF_FFFF);
    total_cnt++;
    if (out !== 64'h2_FFFF_FFFD) $display("FAIL extreme_b_max out=%h exp=%h", out, 64'h2_FFFF_FFFD);
    else pass_cnt++;
  endtask

  task automatic test_booth_digits();
    logic [31:0] vb [4] = '{32'h9249_2492, 32'h6DB6_DB6D, 32'h8000_0000, 32'hAAAA_AAAA};
    logic [63:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      drive(32'h8765_4321, vb[i]);
      exp_v = 64'(32'h8765_4321) * 64'(vb[i]);
      total_cnt++;
      if (out !== exp_v) $display("FAIL booth_%0d out=%h exp=%h", i, out, exp_v);
      else pass_cnt++;
    end
    drive(32'd7, 32'h8000_0000);
    total_cnt++;
    if (out !== 64'h3_8000_0000) $display("FAIL booth_msb out=%h exp=%h", out, 64'h3_8000_0000);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    drive(32'd1000, 32'd1000);
    total_cnt++;
    if (out !== 64'd1000000) $display("FAIL async_pre out=%h exp=%h", out, 64'd1000000);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out !== 64'd0) $display("FAIL async_clear out=%h exp=%h", out, 64'd0);
    else pass_cnt++;
    @(negedge clk);
    a = 32'd50;
    b = 32'd60;
    @(posedge clk);
    #1;
    total_cnt++;
    if (out !== 64'd0) $display("FAIL async_hold out=%h exp=%h", out, 64'd0);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total_cnt++;
    if (out !== 64'd3000) $display("FAIL async_release out=%h exp=%h", out, 64'd3000);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] ra, rb;
    logic [63:0] exp_v;
    int errs;
    errs = 0;
    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      drive(ra, rb);
      exp_v = 64'(ra) * 64'(rb);
      total_cnt++;
      if (out !== exp_v) begin
        if (errs < 10) $display("FAIL random_%0d a=%h b=%h out=%h exp=%h", i, ra, rb, out, exp_v);
        errs++;
      end else begin
        pass_cnt++;
      end
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_back_to_back();
    test_extremes();
    test_booth_digits();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
